lsu_arbiter_multi: RTL and testbench

- Parametrised multi-channel load/store unit: NUM_CHANNELS thread lanes share one external data-memory port.
- Each lane posts one read or write request and receives a one-cycle response pulse.
- A round-robin arbiter serialises requests onto the memory port with a valid/ready handshake, so memory latency can vary.
- Sits between per-thread register files/compute units and the data-memory controller.

---
 rtl/lsu_arbiter_multi_if.sv | 31 +++
 rtl/lsu_arbiter_multi.sv | 117 +++++++++++
 tb/tb_lsu_arbiter_multi.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_arbiter_multi_if.sv
// lsu_arbiter_multi_if: lane request/response and memory-port bundle for lsu_arbiter_multi.
// Lane side : req_valid/req_write/req_addr/req_wdata in, resp_valid/resp_rdata/busy out.
// Memory side: mem_valid/mem_write/mem_addr/mem_wdata out, mem_ready/mem_rdata in.
// slave = the arbiter's view, master = the view of whatever drives lanes and models memory.
interface lsu_arbiter_multi_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8
);
    logic [NUM_CHANNELS-1:0]            req_valid;
    logic [NUM_CHANNELS-1:0]            req_write;
    logic [NUM_CHANNELS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CHANNELS-1:0]            resp_valid;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] resp_rdata;
    logic [NUM_CHANNELS-1:0]            busy;
    logic                               mem_valid;
    logic                               mem_write;
    logic [ADDR_WIDTH-1:0]              mem_addr;
    logic [DATA_WIDTH-1:0]              mem_wdata;
    logic                               mem_ready;
    logic [DATA_WIDTH-1:0]              mem_rdata;
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
        output resp_valid, resp_rdata, busy, mem_valid, mem_write, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_ready, mem_rdata,
        input  resp_valid, resp_rdata, busy, mem_valid, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_arbiter_multi.sv
// lsu_arbiter_multi: NUM_CHANNELS load/store lanes sharing one memory port via round-robin arbitration.
// Ports: clk, reset (sync, active-high), bus (lsu_arbiter_multi_if.slave) carrying
// per-lane requests/responses/busy and the registered valid/ready memory port.
module lsu_arbiter_multi #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    lsu_arbiter_multi_if.slave    bus
);
    localparam int IW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
    typedef enum logic [1:0] {IDLE, PENDING, ISSUED, DONE} state_t;
    state_t                 r_state     [NUM_CHANNELS];
    state_t                 w_state_nxt [NUM_CHANNELS];
    logic                   r_wr        [NUM_CHANNELS];
    logic [ADDR_WIDTH-1:0]  r_addr      [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]  r_wdata     [NUM_CHANNELS];
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] r_rdata;
    logic [IW-1:0]          r_ptr;
    logic                   r_mem_valid;
    logic                   r_mem_write;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_wdata;
    logic                   w_free;
    logic                   w_gnt;
    logic [IW-1:0]          w_gnt_idx;
    logic [NUM_CHANNELS-1:0] w_busy;
    logic [NUM_CHANNELS-1:0] w_resp;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % NUM_CHANNELS);
    endfunction

    // Port frees up in the same edge the owner completes, so the next grant has no bubble.
    assign w_free = !r_mem_valid || bus.mem_ready;

    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (w_free && !w_gnt && r_state[wrap(int'(r_ptr) + k)] == PENDING) begin
                w_gnt     = 1'b1;
                w_gnt_idx = wrap(int'(r_ptr) + k);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++)
            r_state[i] <= reset ? IDLE : w_state_nxt[i];
    end

    // ISSUED implies mem_valid, so mem_ready here always belongs to this lane.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_state_nxt[i] = r_state[i];
            unique case (r_state[i])
                IDLE:    w_state_nxt[i] = bus.req_valid[i] ? PENDING : IDLE;
                PENDING: w_state_nxt[i] = (w_gnt && w_gnt_idx == IW'(i)) ? ISSUED : PENDING;
                ISSUED:  w_state_nxt[i] = bus.mem_ready ? DONE : ISSUED;
                default: w_state_nxt[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_busy[i] = r_state[i] != IDLE;
            w_resp[i] = r_state[i] == DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_wr[i]    <= 1'b0;
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
            end
            r_rdata     <= '0;
            r_ptr       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (r_state[i] == IDLE && bus.req_valid[i]) begin
                    r_wr[i]    <= bus.req_write[i];
                    r_addr[i]  <= bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    r_wdata[i] <= bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
                if (r_state[i] == ISSUED && bus.mem_ready && !r_wr[i])
                    r_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_rdata;
            end
            if (w_gnt) begin
                r_mem_valid <= 1'b1;
                r_mem_write <= r_wr[w_gnt_idx];
                r_mem_addr  <= r_addr[w_gnt_idx];
                r_mem_wdata <= r_wdata[w_gnt_idx];
                r_ptr       <= (w_gnt_idx == IW'(NUM_CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;
            end else if (bus.mem_ready) begin
                r_mem_valid <= 1'b0;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.resp_valid = w_resp;
    assign bus.resp_rdata = r_rdata;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_lsu_arbiter_multi.sv
// tb_lsu_arbiter_multi: directed scenarios for lsu_arbiter_multi against a small memory model.
module tb_lsu_arbiter_multi;
    localparam int N = 4, AW = 8, DW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [7:0] mem  [256];
    logic       seen [256] = '{default: 1'b0};

    always #5 clk = ~clk;

    lsu_arbiter_multi_if #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
    lsu_arbiter_multi #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Unwritten locations return a fixed pattern: 0x20 -> 0x3C, else low nibble doubled.
    always @(posedge clk) begin
        if (bus.mem_valid && bus.mem_ready && bus.mem_write) begin
            mem[bus.mem_addr]  <= bus.mem_wdata;
            seen[bus.mem_addr] <= 1'b1;
        end
    end
    assign bus.mem_rdata = seen[bus.mem_addr] ? mem[bus.mem_addr] :
                           (bus.mem_addr == 8'h20 ? 8'h3C : {bus.mem_addr[3:0], bus.mem_addr[3:0]});

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.req_valid[i]          = v;
        bus.req_write[i]          = w;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) set_lane(i, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_all();
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (bus.busy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL reset_resp_valid: got %h want 0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h want 0", bus.resp_rdata); end
        checks++; if ({bus.mem_valid, bus.mem_write} !== 2'b00) begin errors++; $display("FAIL reset_mem_ctl: got %b want 00", {bus.mem_valid, bus.mem_write}); end
        checks++; if ({bus.mem_addr, bus.mem_wdata} !== 16'h0) begin errors++; $display("FAIL reset_mem_bus: got %h want 0", {bus.mem_addr, bus.mem_wdata}); end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        set_lane(0, 1'b1, 1'b1, 8'h10, 8'hA5);
        tick();
        checks++; if ({bus.busy, bus.mem_valid} !== 5'b0001_0) begin errors++; $display("FAIL st_pending: got %b want 00010", {bus.busy, bus.mem_valid}); end
        set_lane(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checks++; if ({bus.mem_valid, bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {2'b11, 8'h10, 8'hA5}) begin errors++; $display("FAIL st_issue: got %b %h %h want 11 10 a5", {bus.mem_valid, bus.mem_write}, bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL st_resp_early: got %h want 0", bus.resp_valid); end
        tick();
        checks++; if (bus.resp_valid !== 4'h1) begin errors++; $display("FAIL st_resp: got %h want 1", bus.resp_valid); end
        tick();
        checks++; if ({bus.resp_valid, bus.busy} !== 8'h00) begin errors++; $display("FAIL st_idle: got %h want 00", {bus.resp_valid, bus.busy}); end
        set_lane(0, 1'b1, 1'b0, 8'h10, 8'h00);
        tick();
        set_lane(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checks++; if ({bus.mem_valid, bus.mem_write, bus.mem_addr} !== {2'b10, 8'h10}) begin errors++; $display("FAIL ld_issue: got %b %h want 10 10", {bus.mem_valid, bus.mem_write}, bus.mem_addr); end
        tick();
        checks++; if (bus.resp_valid !== 4'h1) begin errors++; $display("FAIL ld_resp: got %h want 1", bus.resp_valid); end
        checks++; if (bus.resp_rdata[7:0] !== 8'hA5) begin errors++; $display("FAIL ld_rdata: got %h want a5", bus.resp_rdata[7:0]); end
        tick();
        checks++; if (bus.busy !== 4'h0) begin errors++; $display("FAIL ld_busy_clear: got %h want 0", bus.busy); end
    endtask

    task automatic test_all_lanes();
        logic [7:0] exp_addr [4] = '{8'h02, 8'h03, 8'h04, 8'h00};
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, 1'b0, 8'(i + 1), 8'h00);
        tick();
        checks++; if ({bus.busy, bus.mem_valid} !== 5'b1111_0) begin errors++; $display("FAIL all_pending: got %b want 11110", {bus.busy, bus.mem_valid}); end
        clear_all();
        tick();
        checks++; if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 8'h01}) begin errors++; $display("FAIL all_grant0: got %b %h want 1 01", bus.mem_valid, bus.mem_addr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({bus.mem_valid, bus.mem_addr, bus.resp_valid} !== {1'b1, exp_addr[k], 4'(1 << k)}) begin errors++; $display("FAIL all_grant%0d: got %b %h %h want 1 %h %h", k + 1, bus.mem_valid, bus.mem_addr, bus.resp_valid, exp_addr[k], 4'(1 << k)); end
        end
        tick();
        checks++; if ({bus.mem_valid, bus.resp_valid} !== 5'b0_1000) begin errors++; $display("FAIL all_last: got %b want 01000", {bus.mem_valid, bus.resp_valid}); end
        checks++; if (bus.resp_rdata !== 32'h44332211) begin errors++; $display("FAIL all_rdata: got %h want 44332211", bus.resp_rdata); end
        tick();
        checks++; if (bus.busy !== 4'h0) begin errors++; $display("FAIL all_busy_clear: got %h want 0", bus.busy); end
        set_lane(1, 1'b1, 1'b0, 8'h06, 8'h00);
        set_lane(0, 1'b1, 1'b0, 8'h05, 8'h00);
        tick();
        clear_all();
        tick();
        checks++; if (bus.mem_addr !== 8'h05) begin errors++; $display("FAIL ptr_wrap_first: got %h want 05", bus.mem_addr); end
        tick();
        checks++; if (bus.mem_addr !== 8'h06) begin errors++; $display("FAIL ptr_wrap_second: got %h want 06", bus.mem_addr); end
        tick();
        tick();
        checks++; if (bus.resp_rdata !== 32'h44336655) begin errors++; $display("FAIL ptr_wrap_rdata: got %h want 44336655", bus.resp_rdata); end
    endtask

    task automatic test_fairness();
        do_reset();
        set_lane(0, 1'b1, 1'b0, 8'h30, 8'h00);
        tick();
        tick();
        checks++; if (bus.mem_addr !== 8'h30) begin errors++; $display("FAIL fair_first: got %h want 30", bus.mem_addr); end
        set_lane(2, 1'b1, 1'b0, 8'h32, 8'h00);
        tick();
        checks++; if ({bus.busy, bus.resp_valid, bus.mem_valid} !== 9'b0101_0001_0) begin errors++; $display("FAIL fair_done0: got %b want 010100010", {bus.busy, bus.resp_valid, bus.mem_valid}); end
        set_lane(2, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checks++; if ({bus.mem_valid, bus.mem_addr, bus.busy} !== {1'b1, 8'h32, 4'b0100}) begin errors++; $display("FAIL fair_lane2: got %b %h %b want 1 32 0100", bus.mem_valid, bus.mem_addr, bus.busy); end
        tick();
        checks++; if ({bus.resp_valid, bus.busy} !== 8'b0100_0101) begin errors++; $display("FAIL fair_rerequest: got %b want 01000101", {bus.resp_valid, bus.busy}); end
        set_lane(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checks++; if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 8'h30}) begin errors++; $display("FAIL fair_lane0_again: got %b %h want 1 30", bus.mem_valid, bus.mem_addr); end
        tick();
        tick();
        checks++; if ({bus.busy, bus.resp_rdata[23:16]} !== {4'h0, 8'h22}) begin errors++; $display("FAIL fair_end: got %h %h want 0 22", bus.busy, bus.resp_rdata[23:16]); end
    endtask

    task automatic test_wait_states();
        bus.mem_ready = 1'b0;
        set_lane(1, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        set_lane(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        for (int c = 0; c < 6; c++) begin
            checks++; if ({bus.mem_valid, bus.mem_write, bus.mem_addr, bus.resp_valid} !== {2'b10, 8'h20, 4'h0}) begin errors++; $display("FAIL wait_hold%0d: got %b %h %h want 10 20 0", c, {bus.mem_valid, bus.mem_write}, bus.mem_addr, bus.resp_valid); end
            if (c == 5) bus.mem_ready = 1'b1;
            tick();
        end
        checks++; if ({bus.resp_valid, bus.resp_rdata[15:8]} !== {4'b0010, 8'h3C}) begin errors++; $display("FAIL wait_resp: got %b %h want 0010 3c", bus.resp_valid, bus.resp_rdata[15:8]); end
        tick();
        checks++; if ({bus.resp_valid, bus.busy} !== 8'h00) begin errors++; $display("FAIL wait_pulse_width: got %h want 00", {bus.resp_valid, bus.busy}); end
    endtask

    task automatic test_busy_ignore();
        set_lane(1, 1'b1, 1'b1, 8'h40, 8'h77);
        tick();
        set_lane(1, 1'b1, 1'b0, 8'h55, 8'h99);
        bus.mem_ready = 1'b0;
        tick();
        checks++; if ({bus.mem_write, bus.mem_addr, bus.mem_wdata} !== {1'b1, 8'h40, 8'h77}) begin errors++; $display("FAIL ign_issue: got %b %h %h want 1 40 77", bus.mem_write, bus.mem_addr, bus.mem_wdata); end
        bus.mem_ready = 1'b1;
        tick();
        checks++; if ({bus.resp_valid, bus.mem_valid} !== 5'b0010_0) begin errors++; $display("FAIL ign_done: got %b want 00100", {bus.resp_valid, bus.mem_valid}); end
        tick();
        set_lane(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        checks++; if ({bus.busy, bus.mem_valid} !== 5'b0000_0) begin errors++; $display("FAIL ign_no_second: got %b want 00000", {bus.busy, bus.mem_valid}); end
        checks++; if (mem[8'h40] !== 8'h77) begin errors++; $display("FAIL ign_stored: got %h want 77", mem[8'h40]); end
        checks++; if (bus.resp_rdata[15:8] !== 8'h3C) begin errors++; $display("FAIL ign_rdata_kept: got %h want 3c", bus.resp_rdata[15:8]); end
    endtask

    task automatic test_reset_mid();
        bus.mem_ready = 1'b0;
        set_lane(0, 1'b1, 1'b0, 8'h08, 8'h00);
        tick();
        set_lane(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        set_lane(2, 1'b1, 1'b0, 8'h62, 8'h00);
        set_lane(3, 1'b1, 1'b0, 8'h63, 8'h00);
        tick();
        checks++; if ({bus.busy, bus.mem_valid, bus.mem_addr} !== {4'b1101, 1'b1, 8'h08}) begin errors++; $display("FAIL rmid_before: got %b %b %h want 1101 1 08", bus.busy, bus.mem_valid, bus.mem_addr); end
        clear_all();
        reset = 1'b1;
        tick();
        checks++; if ({bus.busy, bus.mem_valid, bus.resp_valid} !== 9'h0) begin errors++; $display("FAIL rmid_ctl: got %b want 000000000", {bus.busy, bus.mem_valid, bus.resp_valid}); end
        checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", bus.resp_rdata); end
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        set_lane(3, 1'b1, 1'b0, 8'h04, 8'h00);
        tick();
        checks++; if ({bus.busy, bus.mem_valid} !== 5'b1000_0) begin errors++; $display("FAIL rmid_pending: got %b want 10000", {bus.busy, bus.mem_valid}); end
        clear_all();
        tick();
        checks++; if ({bus.mem_valid, bus.mem_write, bus.mem_addr} !== {2'b10, 8'h04}) begin errors++; $display("FAIL rmid_issue: got %b %h want 10 04", {bus.mem_valid, bus.mem_write}, bus.mem_addr); end
        tick();
        checks++; if ({bus.resp_valid, bus.resp_rdata} !== {4'b1000, 32'h44000000}) begin errors++; $display("FAIL rmid_resp: got %b %h want 1000 44000000", bus.resp_valid, bus.resp_rdata); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_all_lanes();
        test_fairness();
        test_wait_states();
        test_busy_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
